// File: rtl/klein_pkg.sv
// Purpose : shared types and constants for the KLEIN-64 stream sequencer.
// Latency : n/a (package only).
// Backpressure : n/a.
// Contents: FSM state encoding, block width, mode-register bit positions, default watchdog limit.
package klein_pkg;

    localparam int BLOCK_W         = 64;
    localparam int DEFAULT_TIMEOUT = 64;

    // Bit positions inside the latched mode register.
    localparam int MODE_ENC_BIT = 0;
    localparam int MODE_CBC_BIT = 1;

    typedef enum logic [2:0] {
        ST_UNKEYED = 3'd0,
        ST_KINIT   = 3'd1,
        ST_KWAIT   = 3'd2,
        ST_READY   = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_BWAIT   = 3'd5
    } state_t;

endpackage

// File: rtl/klein_cbc_chain.sv
// Purpose : CBC chaining register plus the pre-core / post-core XOR selection.
// Latency : combinational core_in/result; chain updates on the clock edge.
// Backpressure : none; the controller decides when load_iv/update fire.
// Ports: clk/reset_n; load_iv+iv reload the chain; update advances it after a block;
//        encdec/cbc select the mode; in_block/saved_in/core_out are the data taps;
//        core_in feeds the core, result is the final output block.
module klein_cbc_chain
    import klein_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_iv,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               update,
    input  logic               encdec,
    input  logic               cbc,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [BLOCK_W-1:0] saved_in,
    input  logic [BLOCK_W-1:0] core_out,
    output logic [BLOCK_W-1:0] core_in,
    output logic [BLOCK_W-1:0] result
);

    logic [BLOCK_W-1:0] chain;

    // Encrypt chains on ciphertext (core output); decrypt chains on the
    // ciphertext that was fed in, which the controller keeps in saved_in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
        end else if (load_iv) begin
            chain <= iv;
        end else if (update && cbc) begin
            chain <= encdec ? core_out : saved_in;
        end
    end

    always_comb begin
        core_in = in_block;
        if (cbc && encdec) begin
            core_in = in_block ^ chain;
        end
    end

    always_comb begin
        result = core_out;
        if (cbc && !encdec) begin
            result = core_out ^ chain;
        end
    end

endmodule

// File: rtl/klein_stream_ctrl.sv
// Purpose : sequences one KLEIN-64 core over a block stream (key init, ECB/CBC, watchdog).
// Latency : 2 + core latency + 1 cycles per block; one block in flight at a time.
// Backpressure : a held result blocks new input and config until iout_ready consumes it.
// Ports: icfg_* config handshake; iin_*/oin_ready input stream; oout_*/iout_ready result;
//        ocore_*/icore_* core interface; obusy/oerror/oblk_count status.
module klein_stream_ctrl
    import klein_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic               iclk,
    input  logic               ireset_n,
    input  logic               icfg_valid,
    output logic               ocfg_ready,
    input  logic [BLOCK_W-1:0] icfg_key,
    input  logic [BLOCK_W-1:0] icfg_iv,
    input  logic               icfg_encdec,
    input  logic               icfg_cbc,
    input  logic               iin_valid,
    output logic               oin_ready,
    input  logic [BLOCK_W-1:0] iin_block,
    output logic               oout_valid,
    input  logic               iout_ready,
    output logic [BLOCK_W-1:0] oout_block,
    output logic               ocore_init,
    output logic               ocore_next,
    output logic               ocore_encdec,
    output logic [BLOCK_W-1:0] ocore_key,
    output logic [BLOCK_W-1:0] ocore_block,
    input  logic               icore_ready,
    input  logic               icore_result_valid,
    input  logic [BLOCK_W-1:0] icore_block,
    output logic               obusy,
    output logic               oerror,
    output logic [CNT_W-1:0]   oblk_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [WD_W-1:0]    wdog;
    logic [1:0]         mode;
    logic [BLOCK_W-1:0] saved_in;
    logic [BLOCK_W-1:0] chain_core_in;
    logic [BLOCK_W-1:0] chain_result;
    logic               cfg_acc;
    logic               in_acc;
    logic               core_done;
    logic               wd_expire;

    assign cfg_acc      = icfg_valid && ocfg_ready;
    assign in_acc       = iin_valid && oin_ready;
    assign ocore_encdec = mode[MODE_ENC_BIT];
    assign obusy        = !(state == ST_UNKEYED || state == ST_READY) || oout_valid;

    klein_cbc_chain u_chain (
        .clk      (iclk),
        .reset_n  (ireset_n),
        .load_iv  (cfg_acc),
        .iv       (icfg_iv),
        .update   (core_done),
        .encdec   (mode[MODE_ENC_BIT]),
        .cbc      (mode[MODE_CBC_BIT]),
        .in_block (iin_block),
        .saved_in (saved_in),
        .core_out (icore_block),
        .core_in  (chain_core_in),
        .result   (chain_result)
    );

    // Readies are gated by reset so nothing appears accepted while reset is held.
    always_comb begin
        state_nxt  = state;
        ocfg_ready = 1'b0;
        oin_ready  = 1'b0;
        ocore_init = 1'b0;
        ocore_next = 1'b0;
        core_done  = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            ST_UNKEYED: begin
                ocfg_ready = ireset_n && !oout_valid;
                if (icfg_valid && ocfg_ready) state_nxt = ST_KINIT;
            end
            ST_KINIT: begin
                ocore_init = 1'b1;
                state_nxt  = ST_KWAIT;
            end
            ST_KWAIT: begin
                if (icore_ready) begin
                    state_nxt = ST_READY;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = ST_UNKEYED;
                end
            end
            ST_READY: begin
                ocfg_ready = ireset_n && !oout_valid;
                // Config has priority over data offered in the same cycle.
                oin_ready  = ireset_n && !oout_valid && !icfg_valid;
                if (icfg_valid && ocfg_ready) begin
                    state_nxt = ST_KINIT;
                end else if (iin_valid && oin_ready) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ocore_next = 1'b1;
                state_nxt  = ST_BWAIT;
            end
            ST_BWAIT: begin
                if (icore_ready && icore_result_valid) begin
                    core_done = 1'b1;
                    state_nxt = ST_READY;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = ST_UNKEYED;
                end
            end
            default: state_nxt = ST_UNKEYED;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            state       <= ST_UNKEYED;
            wdog        <= '0;
            mode        <= '0;
            ocore_key   <= '0;
            ocore_block <= '0;
            saved_in    <= '0;
            oout_valid  <= 1'b0;
            oout_block  <= '0;
            oerror      <= 1'b0;
            oblk_count  <= '0;
        end else begin
            state <= state_nxt;

            if (cfg_acc) begin
                ocore_key          <= icfg_key;
                mode[MODE_ENC_BIT] <= icfg_encdec;
                mode[MODE_CBC_BIT] <= icfg_cbc;
                oblk_count         <= '0;
                oerror             <= 1'b0;
            end

            if (state == ST_KINIT || state == ST_ISSUE) begin
                wdog <= '0;
            end else if (state == ST_KWAIT || state == ST_BWAIT) begin
                wdog <= wdog + WD_W'(1);
            end

            if (in_acc) begin
                ocore_block <= chain_core_in;
                saved_in    <= iin_block;
            end

            // A result can only complete while no output is pending.
            if (core_done) begin
                oout_block <= chain_result;
                oout_valid <= 1'b1;
                oblk_count <= oblk_count + CNT_W'(1);
            end else if (oout_valid && iout_ready) begin
                oout_valid <= 1'b0;
            end

            if (wd_expire) oerror <= 1'b1;
        end
    end

endmodule

// File: tb/tb_klein_stream_ctrl.sv
module tb_klein_stream_ctrl;

    localparam logic [63:0] KC = 64'hA5A5_A5A5_A5A5_A5A5;

    logic        iclk = 1'b0;
    logic        ireset_n = 1'b0;
    logic        icfg_valid = 1'b0;
    logic        ocfg_ready;
    logic [63:0] icfg_key = '0;
    logic [63:0] icfg_iv = '0;
    logic        icfg_encdec = 1'b0;
    logic        icfg_cbc = 1'b0;
    logic        iin_valid = 1'b0;
    logic        oin_ready;
    logic [63:0] iin_block = '0;
    logic        oout_valid;
    logic        iout_ready = 1'b0;
    logic [63:0] oout_block;
    logic        ocore_init, ocore_next, ocore_encdec;
    logic [63:0] ocore_key, ocore_block;
    logic        icore_ready, icore_result_valid;
    logic [63:0] icore_block;
    logic        obusy, oerror;
    logic [15:0] oblk_count;

    always #5 iclk = ~iclk;

    klein_stream_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut (
        .iclk(iclk), .ireset_n(ireset_n),
        .icfg_valid(icfg_valid), .ocfg_ready(ocfg_ready), .icfg_key(icfg_key),
        .icfg_iv(icfg_iv), .icfg_encdec(icfg_encdec), .icfg_cbc(icfg_cbc),
        .iin_valid(iin_valid), .oin_ready(oin_ready), .iin_block(iin_block),
        .oout_valid(oout_valid), .iout_ready(iout_ready), .oout_block(oout_block),
        .ocore_init(ocore_init), .ocore_next(ocore_next), .ocore_encdec(ocore_encdec),
        .ocore_key(ocore_key), .ocore_block(ocore_block),
        .icore_ready(icore_ready), .icore_result_valid(icore_result_valid),
        .icore_block(icore_block),
        .obusy(obusy), .oerror(oerror), .oblk_count(oblk_count)
    );

    // Behavioural core: drops ready on the init/next edge, returns block ^ KC
    // (either direction) core_lat cycles later; 'hang' freezes it forever.
    int          core_lat = 5;
    bit          hang = 1'b0;
    int          busy_cnt;
    bit          was_next;
    logic [63:0] pend;

    always @(posedge iclk) begin
        if (!ireset_n) begin
            icore_ready        <= 1'b1;
            icore_result_valid <= 1'b0;
            icore_block        <= '0;
            busy_cnt           <= 0;
            was_next           <= 1'b0;
            pend               <= '0;
        end else if (ocore_init) begin
            icore_ready        <= 1'b0;
            icore_result_valid <= 1'b0;
            busy_cnt           <= core_lat;
            was_next           <= 1'b0;
        end else if (ocore_next) begin
            icore_ready        <= 1'b0;
            icore_result_valid <= 1'b0;
            busy_cnt           <= core_lat;
            was_next           <= 1'b1;
            pend               <= ocore_block ^ KC;
        end else if (busy_cnt != 0 && !hang) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                icore_ready        <= 1'b1;
                icore_result_valid <= was_next;
                icore_block        <= pend;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (obusy && n < 300) begin
            @(negedge iclk);
            n++;
        end
        chk({name, "_idle_timeout"}, 64'(obusy), 64'd0);
    endtask

    task automatic configure(input logic [63:0] key, input logic [63:0] iv,
                             input logic enc, input logic cbc);
        int n = 0;
        @(negedge iclk);
        icfg_valid = 1'b1; icfg_key = key; icfg_iv = iv;
        icfg_encdec = enc; icfg_cbc = cbc;
        #1;
        while (!ocfg_ready && n < 300) begin
            @(negedge iclk); #1; n++;
        end
        chk("cfg_ready_timeout", 64'(ocfg_ready), 64'd1);
        @(posedge iclk);
        @(negedge iclk);
        icfg_valid = 1'b0;
        chk("init_pulse", 64'(ocore_init), 64'd1);
        chk("init_not_next", 64'(ocore_next), 64'd0);
        chk("cfg_key", ocore_key, key);
        chk("cfg_encdec", 64'(ocore_encdec), 64'(enc));
        chk("cfg_err_clear", 64'(oerror), 64'd0);
        @(negedge iclk);
        chk("init_one_cycle", 64'(ocore_init), 64'd0);
        wait_idle("cfg");
        chk("cfg_count_zero", 64'(oblk_count), 64'd0);
    endtask

    // Push one block, check the core input, wait for and consume the result.
    task automatic send_block(input logic [63:0] din, input logic [63:0] exp_core,
                              input logic [63:0] exp_out, input int hold);
        int n = 0;
        @(negedge iclk);
        iin_valid = 1'b1; iin_block = din;
        #1;
        while (!oin_ready && n < 300) begin
            @(negedge iclk); #1; n++;
        end
        chk("in_ready_timeout", 64'(oin_ready), 64'd1);
        @(posedge iclk);
        @(negedge iclk);
        iin_valid = 1'b0;
        chk("next_pulse", 64'(ocore_next), 64'd1);
        chk("core_block", ocore_block, exp_core);
        n = 0;
        while (!oout_valid && n < 300) begin
            @(negedge iclk); n++;
        end
        chk("out_valid_timeout", 64'(oout_valid), 64'd1);
        chk("out_block", oout_block, exp_out);
        repeat (hold) @(negedge iclk);
        iout_ready = 1'b1;
        @(negedge iclk);
        iout_ready = 1'b0;
        chk("out_cleared", 64'(oout_valid), 64'd0);
    endtask

    typedef struct {
        bit          new_cfg;
        logic        enc;
        logic        cbc;
        logic [63:0] iv;
        logic [63:0] din;
        logic [63:0] exp_core;
        logic [63:0] exp_out;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [63:0] held;
        logic [63:0] prev, p, ec, eo;
        int exp_cnt;
        int n;
        bit early;

        tbl[0] = '{1, 1, 0, 64'h0, 64'h0, 64'h0, KC};
        tbl[1] = '{0, 1, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5A5A_5A5A_5A5A_5A5A};
        tbl[2] = '{0, 1, 0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'hA486_E0C2_2C0E_684A};
        tbl[3] = '{1, 1, 1, 64'h1111_1111_1111_1111, 64'h0, 64'h1111_1111_1111_1111, 64'hB4B4_B4B4_B4B4_B4B4};
        tbl[4] = '{0, 1, 1, 64'h0, 64'h0, 64'hB4B4_B4B4_B4B4_B4B4, 64'h1111_1111_1111_1111};
        tbl[5] = '{1, 0, 1, 64'h1111_1111_1111_1111, 64'hB4B4_B4B4_B4B4_B4B4, 64'hB4B4_B4B4_B4B4_B4B4, 64'h0};
        tbl[6] = '{0, 0, 1, 64'h0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 64'h0};

        // Reset state
        ireset_n = 1'b0;
        repeat (3) @(negedge iclk);
        chk("rst_cfg_ready", 64'(ocfg_ready), 64'd0);
        chk("rst_in_ready", 64'(oin_ready), 64'd0);
        chk("rst_out_valid", 64'(oout_valid), 64'd0);
        chk("rst_init", 64'(ocore_init), 64'd0);
        chk("rst_key", ocore_key, 64'd0);
        chk("rst_busy", 64'(obusy), 64'd0);
        chk("rst_err", 64'(oerror), 64'd0);
        chk("rst_count", 64'(oblk_count), 64'd0);
        ireset_n = 1'b1;
        @(negedge iclk);
        chk("unkeyed_cfg_ready", 64'(ocfg_ready), 64'd1);

        // Directed vectors: ECB, CBC encrypt, CBC decrypt
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].new_cfg) begin
                configure(64'h0123_4567_89AB_CDEF, tbl[i].iv, tbl[i].enc, tbl[i].cbc);
                exp_cnt = 0;
            end
            send_block(tbl[i].din, tbl[i].exp_core, tbl[i].exp_out, 0);
            exp_cnt++;
            chk("vec_count", 64'(oblk_count), 64'(exp_cnt));
        end

        // Backpressure: result held 10 cycles, second block taken right after handshake
        configure(64'hCAFE, 64'h0, 1'b1, 1'b0);
        send_block(64'h1234, 64'h1234, 64'h1234 ^ KC, 0);
        @(negedge iclk);
        iin_valid = 1'b1; iin_block = 64'h1111_2222;
        #1;
        n = 0;
        while (oin_ready && n < 5) begin
            @(posedge iclk); @(negedge iclk); iin_valid = 1'b0; n++;
        end
        // The second block above was accepted immediately; use a third for backpressure.
        n = 0;
        while (!oout_valid && n < 300) begin
            @(negedge iclk); n++;
        end
        chk("bp_first_valid", 64'(oout_valid), 64'd1);
        held = oout_block;
        chk("bp_first_data", held, 64'h1111_2222 ^ KC);
        iin_valid = 1'b1; iin_block = 64'h5678;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_in_ready_low", 64'(oin_ready), 64'd0);
            chk("bp_valid_held", 64'(oout_valid), 64'd1);
            chk("bp_data_stable", oout_block, held);
            @(negedge iclk);
        end
        iout_ready = 1'b1;
        @(negedge iclk);
        iout_ready = 1'b0;
        #1;
        chk("bp_cleared", 64'(oout_valid), 64'd0);
        chk("bp_in_ready_after", 64'(oin_ready), 64'd1);
        @(negedge iclk);
        iin_valid = 1'b0;
        chk("bp_second_issue", 64'(ocore_next), 64'd1);
        chk("bp_second_core", ocore_block, 64'h5678);
        n = 0;
        while (!oout_valid && n < 300) begin
            @(negedge iclk); n++;
        end
        chk("bp_second_out", oout_block, 64'h5678 ^ KC);
        iout_ready = 1'b1;
        @(negedge iclk);
        iout_ready = 1'b0;
        chk("bp_count", 64'(oblk_count), 64'd3);

        // Config and input together in READY: config wins, chain reloads
        configure(64'h1, 64'h1111_1111_1111_1111, 1'b1, 1'b1);
        send_block(64'h0, 64'h1111_1111_1111_1111, 64'hB4B4_B4B4_B4B4_B4B4, 0);
        @(negedge iclk);
        icfg_valid = 1'b1; icfg_key = 64'h2; icfg_iv = 64'h2222_2222_2222_2222;
        icfg_encdec = 1'b1; icfg_cbc = 1'b1;
        iin_valid = 1'b1; iin_block = 64'h3333;
        #1;
        chk("sim_in_refused", 64'(oin_ready), 64'd0);
        chk("sim_cfg_ready", 64'(ocfg_ready), 64'd1);
        @(negedge iclk);
        icfg_valid = 1'b0; iin_valid = 1'b0;
        chk("sim_init", 64'(ocore_init), 64'd1);
        chk("sim_no_next", 64'(ocore_next), 64'd0);
        chk("sim_count", 64'(oblk_count), 64'd0);
        wait_idle("sim");
        send_block(64'h0, 64'h2222_2222_2222_2222, 64'h2222_2222_2222_2222 ^ KC, 0);

        // Watchdog: core never answers
        hang = 1'b1;
        @(negedge iclk);
        iin_valid = 1'b1; iin_block = 64'hABC;
        #1;
        chk("wd_in_ready", 64'(oin_ready), 64'd1);
        @(posedge iclk);
        @(negedge iclk);
        iin_valid = 1'b0;
        chk("wd_issue", 64'(ocore_next), 64'd1);
        early = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge iclk);
            if (oerror || oout_valid) early = 1'b1;
        end
        chk("wd_not_early", 64'(early), 64'd0);
        @(negedge iclk);
        chk("wd_error", 64'(oerror), 64'd1);
        chk("wd_no_output", 64'(oout_valid), 64'd0);
        chk("wd_unkeyed_idle", 64'(obusy), 64'd0);
        chk("wd_cfg_ready", 64'(ocfg_ready), 64'd1);
        chk("wd_in_refused", 64'(oin_ready), 64'd0);
        chk("wd_count_kept", 64'(oblk_count), 64'd1);
        hang = 1'b0;
        configure(64'h3, 64'h0, 1'b1, 1'b0);
        chk("wd_error_cleared", 64'(oerror), 64'd0);

        // Random streams against the arithmetic reference
        for (int r = 0; r < 6; r++) begin
            logic        enc, cbc;
            logic [63:0] iv;
            int          nb;
            enc = 1'($urandom_range(0, 1));
            cbc = 1'($urandom_range(0, 1));
            iv  = {$urandom, $urandom};
            core_lat = $urandom_range(1, 8);
            configure({$urandom, $urandom}, iv, enc, cbc);
            prev = iv;
            nb = $urandom_range(3, 8);
            for (int b = 0; b < nb; b++) begin
                p = {$urandom, $urandom};
                if (!cbc) begin
                    ec = p; eo = p ^ KC;
                end else if (enc) begin
                    ec = p ^ prev; eo = ec ^ KC; prev = eo;
                end else begin
                    ec = p; eo = (p ^ KC) ^ prev; prev = p;
                end
                send_block(p, ec, eo, $urandom_range(0, 3));
            end
            chk("rnd_count", 64'(oblk_count), 64'(nb));
        end

        // Reset in the middle of a block
        core_lat = 20;
        @(negedge iclk);
        iin_valid = 1'b1; iin_block = 64'h77;
        @(negedge iclk);
        iin_valid = 1'b0;
        repeat (3) @(negedge iclk);
        ireset_n = 1'b0;
        @(negedge iclk);
        ireset_n = 1'b1;
        chk("mid_rst_busy", 64'(obusy), 64'd0);
        chk("mid_rst_key", ocore_key, 64'd0);
        chk("mid_rst_count", 64'(oblk_count), 64'd0);
        chk("mid_rst_next", 64'(ocore_next), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
